// File: rtl/decode_stage_p_if.sv
// ID/EX pipeline-register bundle between the decode stage (master) and EX (slave).
interface decode_stage_p_if #(
    parameter int XLEN = 32
);
    logic            idex_valid;
    logic [3:0]      idex_ex;
    logic [2:0]      idex_m;
    logic [1:0]      idex_wb;
    logic [4:0]      idex_rs;
    logic [4:0]      idex_rt;
    logic [4:0]      idex_rd;
    logic [XLEN-1:0] idex_imm;
    logic [XLEN-1:0] idex_d1;
    logic [XLEN-1:0] idex_d2;
    logic [XLEN-1:0] idex_pc4;

    modport master (
        output idex_valid, idex_ex, idex_m, idex_wb, idex_rs, idex_rt, idex_rd,
               idex_imm, idex_d1, idex_d2, idex_pc4
    );
    modport slave (
        input  idex_valid, idex_ex, idex_m, idex_wb, idex_rs, idex_rt, idex_rd,
               idex_imm, idex_d1, idex_d2, idex_pc4
    );
endinterface

// File: rtl/decode_stage_p.sv
// Instruction decode: register file, control decoder, ID-resolved beq/bne with
// EX/MEM forwarding, load-use / branch-operand hazard stalls, ID/EX register.
module decode_stage_p #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc_plus4,
    input  logic             wb_we,
    input  logic [4:0]       wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [4:0]       ex_dst,
    input  logic             mem_memread,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_dst,
    input  logic [XLEN-1:0]  mem_alu,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             pc_src,
    output logic [XLEN-1:0]  branch_target,
    output logic             illegal_op,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    decode_stage_p_if.master idex
);
    localparam int AW = $clog2(NREG);

    typedef struct packed {
        logic [3:0] ex;
        logic [2:0] m;
        logic [1:0] wb;
    } ctrl_t;

    logic [5:0]      op;
    logic [4:0]      rs, rt, rd;
    logic [XLEN-1:0] imm;
    ctrl_t           ctrl;
    logic            illegal_dec, uses_rt, is_branch, is_beq;

    assign op  = instr[31:26];
    assign rs  = instr[25:21];
    assign rt  = instr[20:16];
    assign rd  = instr[15:11];
    assign imm = {{(XLEN-16){instr[15]}}, instr[15:0]};

    always_comb begin
        ctrl        = '0;
        illegal_dec = 1'b0;
        uses_rt     = 1'b0;
        case (op)
            6'h00:        begin ctrl = '{4'b1100, 3'b000, 2'b10}; uses_rt = 1'b1; end
            6'h23:        ctrl = '{4'b0001, 3'b010, 2'b11};
            6'h2B:        begin ctrl = '{4'b0001, 3'b001, 2'b00}; uses_rt = 1'b1; end
            6'h08:        ctrl = '{4'b0001, 3'b000, 2'b10};
            6'h04, 6'h05: begin ctrl = '{4'b0010, 3'b100, 2'b00}; uses_rt = 1'b1; end
            default:      illegal_dec = 1'b1;
        endcase
    end

    assign is_branch = ctrl.m[2];
    assign is_beq    = (op == 6'h04);

    // Register file with write-through so a same-cycle write-back is visible.
    logic [XLEN-1:0] rf [NREG];
    logic [AW-1:0]   ra1, ra2, wa;
    logic [XLEN-1:0] rd1, rd2;

    assign ra1 = AW'(rs);
    assign ra2 = AW'(rt);
    assign wa  = AW'(wb_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wb_we && wa != '0) begin
            rf[wa] <= wb_data;
        end
    end

    always_comb begin
        rd1 = rf[ra1];
        rd2 = rf[ra2];
        if (ra1 == '0)                rd1 = '0;
        else if (wb_we && wa == ra1)  rd1 = wb_data;
        if (ra2 == '0)                rd2 = '0;
        else if (wb_we && wa == ra2)  rd2 = wb_data;
    end

    logic ex_rs, ex_rt, mem_rs, mem_rt;
    logic load_use, br_alu, br_load, stall, taken, eq;
    logic [XLEN-1:0] cmp_a, cmp_b;

    assign ex_rs  = (rs != 5'd0) && (ex_dst == rs);
    assign ex_rt  = (rt != 5'd0) && (ex_dst == rt);
    assign mem_rs = (rs != 5'd0) && (mem_dst == rs);
    assign mem_rt = (rt != 5'd0) && (mem_dst == rt);

    assign load_use = ex_memread && (ex_rs || (uses_rt && ex_rt));
    assign br_alu   = is_branch && ex_regwrite && (ex_rs || ex_rt);
    assign br_load  = is_branch && mem_memread && (mem_rs || mem_rt);
    assign stall    = in_valid && (load_use || br_alu || br_load);

    // Only an ALU result in EX/MEM can be forwarded; a load there stalls instead.
    assign cmp_a = (mem_regwrite && !mem_memread && mem_rs) ? mem_alu : rd1;
    assign cmp_b = (mem_regwrite && !mem_memread && mem_rt) ? mem_alu : rd2;
    assign eq    = (cmp_a == cmp_b);
    assign taken = in_valid && is_branch && !stall && (is_beq ? eq : !eq);

    assign pc_write      = !stall;
    assign ifid_write    = !stall;
    assign pc_src        = taken;
    assign ifid_flush    = taken;
    assign branch_target = pc_plus4 + (imm << 2);

    logic issue;
    assign issue = in_valid && !stall && !illegal_dec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex.idex_valid <= 1'b0;
            idex.idex_ex    <= '0;
            idex.idex_m     <= '0;
            idex.idex_wb    <= '0;
            idex.idex_rs    <= '0;
            idex.idex_rt    <= '0;
            idex.idex_rd    <= '0;
            idex.idex_imm   <= '0;
            idex.idex_d1    <= '0;
            idex.idex_d2    <= '0;
            idex.idex_pc4   <= '0;
            illegal_op      <= 1'b0;
            stall_cnt       <= '0;
            flush_cnt       <= '0;
        end else begin
            idex.idex_valid <= issue;
            idex.idex_ex    <= issue ? ctrl.ex : 4'b0;
            idex.idex_m     <= issue ? ctrl.m  : 3'b0;
            idex.idex_wb    <= issue ? ctrl.wb : 2'b0;
            idex.idex_rs    <= rs;
            idex.idex_rt    <= rt;
            idex.idex_rd    <= rd;
            idex.idex_imm   <= imm;
            idex.idex_d1    <= rd1;
            idex.idex_d2    <= rd2;
            idex.idex_pc4   <= pc_plus4;
            if (in_valid && illegal_dec) illegal_op <= 1'b1;
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (taken && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_decode_stage_p.sv
// Directed bench for decode_stage_p: hazards, branch resolution, bypass, counters, reset.
module tb_decode_stage_p;
    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [31:0]      instr;
    logic [XLEN-1:0]  pc_plus4;
    logic             wb_we;
    logic [4:0]       wb_addr;
    logic [XLEN-1:0]  wb_data;
    logic             ex_memread, ex_regwrite;
    logic [4:0]       ex_dst;
    logic             mem_memread, mem_regwrite;
    logic [4:0]       mem_dst;
    logic [XLEN-1:0]  mem_alu;
    logic             pc_write, ifid_write, ifid_flush, pc_src, illegal_op;
    logic [XLEN-1:0]  branch_target;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    decode_stage_p_if #(.XLEN(XLEN)) idex ();

    decode_stage_p #(.XLEN(XLEN), .NREG(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .pc_plus4(pc_plus4),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_dst(ex_dst),
        .mem_memread(mem_memread), .mem_regwrite(mem_regwrite), .mem_dst(mem_dst),
        .mem_alu(mem_alu), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .pc_src(pc_src), .branch_target(branch_target),
        .illegal_op(illegal_op), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .idex(idex)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d);
        return {6'h00, s, t, d, 11'h020};
    endfunction

    task automatic clear_in();
        in_valid = 0; instr = 0; pc_plus4 = 0;
        wb_we = 0; wb_addr = 0; wb_data = 0;
        ex_memread = 0; ex_regwrite = 0; ex_dst = 0;
        mem_memread = 0; mem_regwrite = 0; mem_dst = 0; mem_alu = 0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [XLEN-1:0] d);
        wb_we = 1; wb_addr = a; wb_data = d;
        @(posedge clk); #1;
        wb_we = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        clear_in();
        rst = 0;
        #2;
        chk("rst_valid", idex.idex_valid, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_illegal", illegal_op, 0);
        @(negedge clk); rst = 1;
        tick();

        wb_write(5'd1, 32'h10);
        wb_write(5'd4, 32'h3);
        wb_write(5'd5, 32'h55);
        wb_write(5'd6, 32'h5);
        wb_write(5'd7, 32'h5);

        // lw r2,0(r1)
        in_valid = 1; instr = enc_i(6'h23, 5'd1, 5'd2, 16'd0); pc_plus4 = 32'h40;
        #1 chk("lw_pc_write", pc_write, 1);
        tick();
        chk("lw_valid", idex.idex_valid, 1);
        chk("lw_ctrl", {idex.idex_ex, idex.idex_m, idex.idex_wb}, {4'b0001, 3'b010, 2'b11});
        chk("lw_d1", idex.idex_d1, 32'h10);
        chk("lw_rt", idex.idex_rt, 2);

        // add r3,r2,r4 behind the load: one bubble
        instr = enc_r(5'd2, 5'd4, 5'd3); ex_memread = 1; ex_regwrite = 1; ex_dst = 5'd2;
        #1;
        chk("lu_pc_write", pc_write, 0);
        chk("lu_ifid_write", ifid_write, 0);
        tick();
        chk("lu_bubble_valid", idex.idex_valid, 0);
        chk("lu_bubble_ex", idex.idex_ex, 0);
        ex_memread = 0; ex_regwrite = 0; ex_dst = 0;
        #1 chk("lu_release", pc_write, 1);
        tick();
        chk("add_valid", idex.idex_valid, 1);
        chk("add_ex", idex.idex_ex, 4'b1100);
        chk("add_wb", idex.idex_wb, 2'b10);
        chk("add_d2", idex.idex_d2, 32'h3);
        chk("add_rd", idex.idex_rd, 3);
        chk("stall_cnt_1", stall_cnt, 1);

        // beq r1,r1,+3 from pc_plus4=0x100
        instr = enc_i(6'h04, 5'd1, 5'd1, 16'd3); pc_plus4 = 32'h100;
        #1;
        chk("beq_pc_src", pc_src, 1);
        chk("beq_target", branch_target, 32'h10C);
        chk("beq_flush", ifid_flush, 1);
        tick();
        chk("beq_flush_cnt", flush_cnt, 1);
        chk("beq_m", idex.idex_m, 3'b100);
        chk("beq_wb", idex.idex_wb, 0);
        chk("beq_valid", idex.idex_valid, 1);

        // bne r6,r7 (both 5): not taken without forwarding, taken with mem_alu=9 on r7
        instr = enc_i(6'h05, 5'd6, 5'd7, 16'hFFFF); pc_plus4 = 32'h200;
        #1;
        chk("bne_nofwd_pc_src", pc_src, 0);
        chk("bne_back_target", branch_target, 32'h1FC);
        mem_regwrite = 1; mem_dst = 5'd7; mem_alu = 32'h9;
        #1 chk("bne_fwd_pc_src", pc_src, 1);
        tick();
        chk("bne_flush_cnt", flush_cnt, 2);
        mem_memread = 1;
        #1;
        chk("bne_ld_pc_write", pc_write, 0);
        chk("bne_ld_pc_src", pc_src, 0);
        tick();
        chk("bne_ld_valid", idex.idex_valid, 0);
        chk("stall_cnt_2", stall_cnt, 2);
        chk("flush_cnt_held", flush_cnt, 2);
        mem_memread = 0; mem_regwrite = 0; mem_dst = 0; mem_alu = 0;

        // write-through bypass and r0 protection
        instr = enc_r(5'd3, 5'd0, 5'd1); wb_we = 1; wb_addr = 5'd3; wb_data = 32'hDEAD;
        tick();
        chk("bypass_d1", idex.idex_d1, 32'hDEAD);
        instr = enc_r(5'd0, 5'd0, 5'd1); wb_addr = 5'd0; wb_data = 32'h1234;
        tick();
        chk("r0_bypass_d1", idex.idex_d1, 0);
        wb_we = 0;
        tick();
        chk("r0_read_d2", idex.idex_d2, 0);

        // branch on result of the ALU op in EX: stall; three cycles saturate a 2-bit counter
        instr = enc_i(6'h04, 5'd1, 5'd2, 16'd1); ex_regwrite = 1; ex_dst = 5'd2;
        #1 chk("br_alu_pc_write", pc_write, 0);
        tick();
        chk("stall_cnt_3", stall_cnt, 3);
        tick();
        tick();
        chk("stall_cnt_sat", stall_cnt, 3);
        ex_regwrite = 0; ex_dst = 0;

        // illegal opcode
        instr = {6'h3F, 26'h0};
        #1 chk("ill_pc_write", pc_write, 1);
        tick();
        chk("ill_ctrl", {idex.idex_ex, idex.idex_m, idex.idex_wb}, 0);
        chk("ill_flag", illegal_op, 1);
        in_valid = 0; instr = enc_i(6'h23, 5'd1, 5'd2, 16'd0);
        tick();
        chk("ill_sticky", illegal_op, 1);
        chk("invalid_bubble", idex.idex_valid, 0);

        // asynchronous reset between edges
        in_valid = 1; instr = enc_r(5'd2, 5'd4, 5'd3);
        tick();
        chk("pre_rst_valid", idex.idex_valid, 1);
        #2 rst = 0;
        #1;
        chk("mid_rst_valid", idex.idex_valid, 0);
        chk("mid_rst_wb", idex.idex_wb, 0);
        chk("mid_rst_stall_cnt", stall_cnt, 0);
        chk("mid_rst_illegal", illegal_op, 0);
        @(negedge clk); rst = 1;
        instr = enc_r(5'd5, 5'd0, 5'd1);
        tick();
        chk("post_rst_valid", idex.idex_valid, 1);
        chk("post_rst_r5", idex.idex_d1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/decode_stage_p.md
# decode_stage_p

Parametrised instruction-decode stage for the 5-stage pipeline. It holds the register file and the main control decoder. It resolves beq/bne in ID with an EX/MEM forwarding path, and detects load-use and branch-operand hazards. It launches the ID/EX pipeline register with bubble insertion, and sits between the IF/ID register and the EX stage.

## Interface
- XLEN, 32, datapath width (≥16)
- NREG, 32, architectural registers (power of 2, ≥8); AW = log2(NREG), field width 5 fixed in encoding, upper bits ignored when AW<5
- CNT_W, 16, width of stall/flush performance counters
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  IF/ID register holds a real instruction
- instr  in  32  instruction from IF/ID
- pc_plus4  in  XLEN  PC+4 from IF/ID
- wb_we  in  1  write-back enable
- wb_addr  in  5  write-back register
- wb_data  in  XLEN  write-back data
- ex_memread, ex_regwrite  in  1 each  ID/EX-stage instruction is a load / writes a register (fed back from this block's own outputs by top level)
- ex_dst  in  5  destination of the ID/EX instruction (after RegDst mux)
- mem_memread, mem_regwrite  in  1 each  EX/MEM instruction flags
- mem_dst  in  5  EX/MEM destination
- mem_alu  in  XLEN  EX/MEM ALU result (forward source)
- pc_write, ifid_write  out  1 each  0 = hold PC / hold IF/ID
- ifid_flush  out  1  squash IF/ID on taken branch
- pc_src  out  1  select branch_target
- branch_target  out  XLEN  pc_plus4 + (sext(imm) << 2)
- illegal_op  out  1  sticky; unknown opcode seen with in_valid
- idex_valid, idex_ex[3:0], idex_m[2:0], idex_wb[1:0], idex_rs/rt/rd[4:0], idex_imm[XLEN], idex_d1[XLEN], idex_d2[XLEN], idex_pc4[XLEN]  out  ID/EX register contents
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- Fields: op=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=sext([15:0]) to XLEN.
- Control {EX={RegDst,ALUOp[1:0],ALUSrc}, M={Branch,MemRead,MemWrite}, WB={RegWrite,MemtoReg}}:
  - R-type 0x00: 1100/000/10
  - lw 0x23: 0001/010/11
  - sw 0x2B: 0001/001/00
  - addi 0x08: 0001/000/10
  - beq 0x04 and bne 0x05: 0010/100/00
  - Any other opcode: all zero, and sets illegal_op.
- Register file: NREG×XLEN; r0 reads 0, writes to r0 ignored. Write on clk rising edge. Reads combinational with write-through bypass (wb_we && wb_addr==src && src!=0 returns wb_data).
- uses_rt = R-type, sw, beq, bne. A match requires a nonzero register.
- Hazards (only when in_valid):
  - load-use: ex_memread && ex_dst∈{rs, rt if uses_rt} → stall.
  - branch-ALU: branch && ex_regwrite && ex_dst∈{rs,rt} → stall.
  - branch-load: branch && mem_memread && mem_dst∈{rs,rt} → stall.
- Branch comparator operands: mem_alu if mem_regwrite && !mem_memread && mem_dst==src!=0; else the register-file read.
- taken = branch && !stall && (beq ? eq : !eq).
- Stall: pc_write=0, ifid_write=0, ID/EX loads a bubble (valid=0, ex/m/wb=0, other fields don't-care but driven from decode).
- Taken branch: pc_src=1, ifid_flush=1. ID/EX loads the branch with valid=1 and its M.Branch bit set, WB=0.
- !in_valid: ID/EX loads a bubble, with no hazard and no counting.
- Counters increment once per stall cycle or per taken-branch cycle and saturate at all-ones.

## Timing
- Hazard, pc_src, branch_target, pc_write, ifid_write and ifid_flush are combinational in the same cycle as instr.
- ID/EX outputs are registered, 1-cycle latency.
- A load followed by a dependent instruction costs exactly 1 bubble.
- A branch depending on the immediately preceding ALU op costs 1 stall. On the preceding load it costs 2 stalls: the first from the branch-ALU/load-use rule, the second from the branch-load rule.
- Write-back to a register read in the same cycle returns the new value.
- Reset (rst=0, any time, asynchronous):
  - All ID/EX outputs are 0, including idex_valid=0.
  - Register file cleared to 0.
  - Counters are 0 and illegal_op=0.
  - Combinational outputs follow their inputs.
- After rst deasserts, the first rising edge captures normally.

## Test plan
- Reset mid-stream: assert rst low between edges → idex_valid, idex_wb, stall_cnt and illegal_op are 0 immediately, and r5 later reads 0.
- lw r2,0(r1) then add r3,r2,r4:
  - Add cycle: ex_memread=1, ex_dst=2 → pc_write=0, ifid_write=0.
  - Next edge: idex_valid=0.
  - Following edge: add is issued with idex_ex=1100 and stall_cnt=1.
- beq r1,r1,+3 with pc_plus4=0x100, no hazards → pc_src=1, branch_target=0x10C, ifid_flush=1, flush_cnt=1.
- bne r6,r7 with r6=5, r7=5 but mem_regwrite=1, mem_dst=7, mem_alu=9 → forwarded, taken, pc_src=1. Same case with mem_memread=1 → stall, pc_src=0.
- Bypass: wb_we=1, wb_addr=3, wb_data=0xDEAD while decoding add r1,r3,r0 → idex_d1=0xDEAD after the edge. A write to r0 leaves r0 reading 0.
- Opcode 0x3F with in_valid=1 → control bubble, illegal_op=1 and stays 1. With CNT_W=2, 5 stalls → stall_cnt=3.
